// File: rtl/alu_mul_seq_if.sv
// Bundle between the multiply sequencer, its requester and the external alu.
// slave = sequencer side, master = requester plus alu side.
interface alu_mul_seq_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] product;
  logic         ovf;
  logic         err_o;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [N-1:0] alu_o;
  logic         alu_of;
  logic         alu_uf;
  logic         alu_err;
  logic         alu_zero;

  modport slave (
    input  start, a_in, b_in, alu_o, alu_of, alu_uf, alu_err, alu_zero,
    output busy, done, product, ovf, err_o, alu_a, alu_b, alu_op
  );

  modport master (
    output start, a_in, b_in, alu_o, alu_of, alu_uf, alu_err, alu_zero,
    input  busy, done, product, ovf, err_o, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned multiply by repeated addition through an external alu; done 3*b+1 cycles after start.
// No backpressure: start is sampled only in IDLE, requests while busy or in DONE are dropped.
module alu_mul_seq #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_mul_seq_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ADD, S_DEC, S_DONE} state_t;

  state_t       r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_ovf;
  logic         r_err;
  logic [N-1:0] r_product;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_opa;

  logic [N-1:0] w_alu_a;
  logic [N-1:0] w_alu_b;
  logic [3:0]   w_alu_op;

  // Idle/done park the alu on a harmless add of zeros.
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = 4'b0000;
    case (r_state)
      S_CHECK: begin
        w_alu_op = 4'b0100;
        w_alu_a  = r_cnt;
      end
      S_ADD: begin
        w_alu_op = 4'b0000;
        w_alu_a  = r_acc;
        w_alu_b  = r_opa;
      end
      S_DEC: begin
        w_alu_op = 4'b0001;
        w_alu_a  = r_cnt;
        w_alu_b  = N'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      r_product <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_opa     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_opa   <= bus.a_in;
            r_cnt   <= bus.b_in;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bus.alu_err || bus.alu_zero) begin
            r_err   <= bus.alu_err;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          // An aborted step leaves acc/ovf untouched so product reflects completed adds only.
          if (bus.alu_err) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_acc   <= bus.alu_o;
            r_ovf   <= r_ovf | bus.alu_of;
            r_state <= S_DEC;
          end
        end
        S_DEC: begin
          if (bus.alu_err || bus.alu_uf) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= bus.alu_o;
            r_state <= S_CHECK;
          end
        end
        S_DONE: begin
          r_product <= r_acc;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
  assign bus.ovf     = r_ovf;
  assign bus.err_o   = r_err;
  assign bus.alu_a   = w_alu_a;
  assign bus.alu_b   = w_alu_b;
  assign bus.alu_op  = w_alu_op;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural 4-bit alu stand-in plus product/ovf/timing reference.
module tb_alu_mul_seq;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic inj_err;
  int   n_tests;
  int   n_fail;

  alu_mul_seq_if #(.N(N)) bus ();

  alu_mul_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu stand-in: add, sub, compare; anything else is an illegal op
  always_comb begin
    logic [N:0] sum;
    sum          = '0;
    bus.alu_o    = '0;
    bus.alu_of   = 1'b0;
    bus.alu_uf   = 1'b0;
    bus.alu_err  = inj_err;
    case (bus.alu_op)
      4'b0000: begin
        sum        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_o  = sum[N-1:0];
        bus.alu_of = sum[N];
      end
      4'b0001: begin
        bus.alu_o  = bus.alu_a - bus.alu_b;
        bus.alu_uf = (bus.alu_a < bus.alu_b);
      end
      4'b0100: bus.alu_o = bus.alu_a - bus.alu_b;
      default: bus.alu_err = 1'b1;
    endcase
    bus.alu_zero = (bus.alu_o == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation; repulse = edge index (after acceptance) at which start is pulsed again, 0 = none.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int repulse, input bit inj);
    int done_k, dones, adds, exp_k, full;
    bit injected, finished;
    done_k   = -1;
    dones    = 0;
    adds     = 0;
    injected = 1'b0;
    finished = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    for (int k = 0; k < 80 && !finished; k++) begin
      @(negedge clk);
      bus.start = (k == repulse - 1);
      inj_err   = 1'b0;
      if (bus.busy && !bus.done && bus.alu_op == 4'b0000) begin
        adds++;
        if (inj && !injected) begin
          inj_err  = 1'b1;
          injected = 1'b1;
        end
      end
      if (bus.done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      if (!bus.busy) finished = 1'b1;
    end
    inj_err = 1'b0;
    full  = int'(a) * int'(b);
    exp_k = inj ? 2 : 3 * int'(b) + 1;
    check("finished",    32'(finished), 1);
    check("done_cycle",  done_k, exp_k);
    check("done_pulses", dones, 1);
    check("add_states",  adds, inj ? 1 : int'(b));
    check("product",     bus.product, inj ? 0 : full % 16);
    check("ovf",         bus.ovf, (!inj && full > 15) ? 1 : 0);
    check("err_o",       bus.err_o, inj ? 1 : 0);
    check("idle_alu_op", bus.alu_op, 0);
  endtask

  initial begin
    int dones;
    n_tests   = 0;
    n_fail    = 0;
    inj_err   = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #11;
    check("rst_busy",    bus.busy, 0);
    check("rst_done",    bus.done, 0);
    check("rst_product", bus.product, 0);
    check("rst_ovf",     bus.ovf, 0);
    check("rst_err",     bus.err_o, 0);
    check("rst_alu",     {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd2,  4'd3, 0, 1'b0);
    run_op(4'd3,  4'd3, 0, 1'b0);
    run_op(4'd5,  4'd0, 0, 1'b0);
    run_op(4'd15, 4'd2, 0, 1'b0);
    run_op(4'd1,  4'd1, 0, 1'b0);
    run_op(4'd2,  4'd3, 3, 1'b0);
    run_op(4'd0,  4'd5, 0, 1'b0);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 4'd2;
    bus.b_in  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",    bus.busy, 0);
    check("midrst_product", bus.product, 0);
    check("midrst_flags",   {bus.done, bus.ovf, bus.err_o}, 0);
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);
    rst_n = 1'b1;
    run_op(4'd2, 4'd3, 0, 1'b0);

    run_op(4'd2, 4'd3, 0, 1'b1);

    // start held high: one operation per return to IDLE (period 3*b+3 for b=1)
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 4'd3;
    bus.b_in  = 4'd1;
    @(posedge clk);
    dones = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    check("b2b_dones",   dones, 4);
    check("b2b_product", bus.product, 3);
    repeat (3) @(negedge clk);
    check("b2b_idle", bus.busy, 0);

    for (int i = 0; i < 12; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_op(ra, rb, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
